// File: rtl/db_press_classifier_pkg.sv
// Shared types and default parameters for the press classifier.
package db_press_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int LONG_CYC_DEF = 8;
    localparam int RPT_CYC_DEF  = 4;
    localparam int HW_DEF       = 8;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/db_press_classifier_if.sv
// Button-level input and classified event outputs of the press classifier.
interface db_press_classifier_if
    import db_press_classifier_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             in;
    logic             cnt_clr;
    logic             short_pulse;
    logic             long_pulse;
    logic             rpt_pulse;
    logic [CNT_W-1:0] press_cnt;
    logic             busy;

    modport master (
        output in, cnt_clr,
        input  short_pulse, long_pulse, rpt_pulse, press_cnt, busy
    );

    modport slave (
        input  in, cnt_clr,
        output short_pulse, long_pulse, rpt_pulse, press_cnt, busy
    );
endinterface

// File: rtl/db_press_classifier_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end
endmodule

// File: rtl/db_press_classifier.sv
// Turns a debounced button level into short/long/repeat event pulses and counts presses.
module db_press_classifier
    import db_press_classifier_pkg::*;
#(
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int RPT_CYC  = RPT_CYC_DEF,
    parameter int HW       = HW_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    db_press_classifier_if.slave bus
);
    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] rpt_cnt;
    logic          short_q;
    logic          long_q;
    logic          rpt_q;
    logic          press_done;
    logic [CNT_W-1:0] cnt_q;

    // Same decision the FSM makes when it raises short_pulse or long_pulse.
    assign press_done = (state == PRESS) &&
                        (!bus.in || (hold_cnt == HW'(LONG_CYC - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rpt_cnt  <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            rpt_q    <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in) begin
                        state    <= PRESS;
                        hold_cnt <= HW'(1);
                    end
                end
                PRESS: begin
                    if (!bus.in) begin
                        state   <= IDLE;
                        short_q <= 1'b1;
                    end else if (hold_cnt == HW'(LONG_CYC - 1)) begin
                        state   <= HOLD;
                        long_q  <= 1'b1;
                        rpt_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                HOLD: begin
                    if (!bus.in) begin
                        state <= IDLE;
                    end else if (rpt_cnt == HW'(RPT_CYC - 1)) begin
                        rpt_q   <= 1'b1;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_press_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (press_done),
        .q   (cnt_q)
    );

    assign bus.short_pulse = short_q;
    assign bus.long_pulse  = long_q;
    assign bus.rpt_pulse   = rpt_q;
    assign bus.press_cnt   = cnt_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_db_press_classifier.sv
// Scoreboard bench: each press pushes its expected pulse events, a monitor pops them as pulses appear.
module tb_db_press_classifier;
    localparam int LONG = 8;
    localparam int RPT  = 4;
    localparam int CW   = 4;

    typedef struct {
        int kind;
        int edge_n;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_no = 0;
    ev_t  sb[$];

    db_press_classifier_if #(.CNT_W(CW)) bus ();

    db_press_classifier #(
        .LONG_CYC (LONG),
        .RPT_CYC  (RPT),
        .HW       (8),
        .CNT_W    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // Monitor: pulses are sampled 1 time unit after each rising edge.
    always begin
        int   npulse;
        int   kind;
        ev_t  e;
        @(posedge clk);
        #1;
        edge_no++;
        while (sb.size() > 0 && sb[0].edge_n < edge_no) begin
            e = sb.pop_front();
            check("missed_pulse", 0, e.kind);
        end
        npulse = int'(bus.short_pulse) + int'(bus.long_pulse) + int'(bus.rpt_pulse);
        if (npulse > 0) begin
            kind = bus.short_pulse ? 1 : (bus.long_pulse ? 2 : 3);
            if (npulse > 1) check("exclusive", npulse, 1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", kind, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_edge", edge_no, e.edge_n);
            end
        end
    end

    // n samples high, then one low edge; cnt_clr optionally driven on that release edge.
    task automatic press(input int n, input bit clr_at_release);
        int start;
        start = edge_no + 1;
        if (n < LONG) begin
            sb.push_back('{1, start + n});
        end else begin
            sb.push_back('{2, start + LONG - 1});
            for (int k = 1; LONG + k * RPT <= n; k++)
                sb.push_back('{3, start + LONG - 1 + k * RPT});
        end
        bus.in = 1'b1;
        @(negedge clk);
        check("busy_pressed", int'(bus.busy), 1);
        repeat (n - 1) @(negedge clk);
        bus.in      = 1'b0;
        bus.cnt_clr = clr_at_release;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        check("busy_released", int'(bus.busy), 0);
    endtask

    task automatic clear_cnt();
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        check("cnt_cleared", int'(bus.press_cnt), 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_short"}, int'(bus.short_pulse), 0);
        check({tag, "_long"}, int'(bus.long_pulse), 0);
        check({tag, "_rpt"}, int'(bus.rpt_pulse), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_cnt"}, int'(bus.press_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in      = 1'b1;
        bus.cnt_clr = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        check_quiet("reset1");
        @(negedge clk);
        check_quiet("reset2");
        rst    = 1'b0;
        bus.in = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("idle");

        press(3, 1'b0);
        check("cnt_short3", int'(bus.press_cnt), 1);

        clear_cnt();
        press(7, 1'b0);
        check("cnt_after7", int'(bus.press_cnt), 1);
        press(8, 1'b0);
        check("cnt_after8", int'(bus.press_cnt), 2);

        clear_cnt();
        press(20, 1'b0);
        check("cnt_after20", int'(bus.press_cnt), 1);

        clear_cnt();
        for (int i = 0; i < 15; i++) press(2, 1'b0);
        check("cnt_15", int'(bus.press_cnt), 15);
        press(2, 1'b0);
        check("cnt_saturated", int'(bus.press_cnt), 15);
        press(2, 1'b1);
        check("cnt_clr_wins", int'(bus.press_cnt), 0);

        press(1, 1'b0);
        check("cnt_min_press", int'(bus.press_cnt), 1);
        for (int i = 0; i < 4; i++) begin
            bus.in = 1'b1;
            @(negedge clk);
            bus.in = 1'b0;
            sb.push_back('{1, edge_no + 1});
            @(negedge clk);
        end
        check("cnt_toggle", int'(bus.press_cnt), 5);

        bus.in = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_midpress", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midrst1");
        @(negedge clk);
        check_quiet("midrst2");
        rst = 1'b0;
        press(10, 1'b0);
        check("cnt_after_rst_press", int'(bus.press_cnt), 1);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/db_press_classifier.md
Name: db_press_classifier

Overview:
- Consumes the level output of the button debouncer and converts it into single-cycle event pulses: short press, long press, and auto-repeat while held.
- Keeps a saturating count of completed presses.
- Sits directly downstream of the debouncer and feeds control logic that needs edge-type events instead of a level.

Parameters:
LONG_CYC, 8, consecutive high samples needed to classify a press as long (≥2)
RPT_CYC, 4, cycles between auto-repeat pulses once long (≥1)
HW, 8, hold/repeat counter width; must hold LONG_CYC-1 and RPT_CYC-1
CNT_W, 4, press counter width

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
in  input  1  debounced button level, already synchronous to clk
cnt_clr  input  1  synchronous clear of press_cnt
short_pulse  output  1  one-cycle pulse: press released before LONG_CYC samples
long_pulse  output  1  one-cycle pulse: press reached LONG_CYC samples
rpt_pulse  output  1  one-cycle pulse: every RPT_CYC samples after long_pulse while held
press_cnt  output  CNT_W  saturating count of classified presses
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, hold_cnt=0, rpt_cnt=0, press_cnt=0. All pulses and busy read 0 in the cycle after the reset edge.
- Reset mid-press clears everything. If in is still high after reset, it is treated as a new press, counted from the first post-reset sample.
- All outputs are registered. A pulse is high for exactly one cycle, starting on the edge that decides it.
- The three pulses are mutually exclusive.
- Sample n means the nth consecutive posedge with in=1.
- FSM states:
  - IDLE:
    - in=1 → PRESS, hold_cnt=1.
    - in=0 → stay.
  - PRESS:
    - in=0 → IDLE, short_pulse=1.
    - in=1 and hold_cnt==LONG_CYC-1 → HOLD, long_pulse=1, rpt_cnt=0.
    - Otherwise hold_cnt+1.
    - Result: long_pulse is asserted at sample LONG_CYC. Releasing after 1..LONG_CYC-1 samples gives short_pulse.
  - HOLD:
    - in=0 → IDLE, no pulse.
    - in=1 and rpt_cnt==RPT_CYC-1 → rpt_pulse=1, rpt_cnt=0.
    - Otherwise rpt_cnt+1.
    - Result: rpt_pulse at samples LONG_CYC+k·RPT_CYC, k≥1. With RPT_CYC=1, rpt_pulse every cycle in HOLD.
- press_cnt:
  - +1 on the edge that sets short_pulse or long_pulse.
  - Saturates at 2^CNT_W-1; no wrap.
  - rpt_pulse does not count.
  - cnt_clr wins over a simultaneous increment: result is 0.
- busy = (state != IDLE). It follows the state register, so no extra latency.
- Unused state encodings fall back to IDLE on the next edge, with no pulse.
- in toggling every cycle gives a short_pulse on every release. The block does no filtering; filtering is upstream's job.

Decomposition:
- Shared package holds:
  - state encodings IDLE/PRESS/HOLD as 2-bit constants;
  - default values for LONG_CYC, RPT_CYC, CNT_W.
- One natural sub-module, sat_counter (parameter width W; inputs clk, rst, clr, inc; output q). It implements press_cnt and is reusable elsewhere.
- The hold and repeat counters stay inline in the FSM.

Test Plan (LONG_CYC=8, RPT_CYC=4, CNT_W=4):
- rst high 2 cycles with in=1 → all outputs 0, busy 0 throughout reset. After release, in=0 keeps busy 0.
- in high 3 samples, then low → short_pulse high exactly one cycle after the first low edge; press_cnt=1; busy returns to 0; long/rpt never assert.
- in high 7 samples → short_pulse on release. Repeat with 8 samples → long_pulse at sample 8, and no short_pulse on release; press_cnt=2.
- in high 20 samples → long_pulse at sample 8, rpt_pulse at samples 12, 16, 20 (three pulses); release gives no pulse; press_cnt=1.
- 16 short presses → press_cnt stops at 15. Then cnt_clr on the same edge as a short_pulse → press_cnt=0.
- rst asserted at sample 5 of a held press, then in kept high → no pulses during reset; long_pulse at the 8th post-reset sample; press_cnt=1.
